// File: rtl/widener_pkg.sv
// Shared types and constants for the widener narrow-to-wide bus responder.
// Combinational only; no latency, no flow control of its own.
package widener_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STORE = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam int OFS_W      = 3;
  localparam int BYTE_LANES = 8;
  localparam int HALF_LANES = 4;

  // Halfword accesses are forced aligned, so ofs[0] drops out of the mask.
  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [OFS_W-1:0] ofs,
                                                      input logic             siz);
    if (siz) begin
      lane_mask = 8'b0000_0011 << {ofs[2:1], 1'b0};
    end else begin
      lane_mask = 8'b0000_0001 << ofs;
    end
  endfunction

endpackage

// File: rtl/widener_lane.sv
// Extracts a byte or halfword lane from a dword and extends it to 16 bits.
// Purely combinational; shared by the buffer-hit and slave-fetch paths.
module widener_lane
  import widener_pkg::*;
(
  input  logic [63:0]      dword_i,
  input  logic [OFS_W-1:0] ofs_i,
  input  logic             siz_i,
  input  logic             signed_i,
  output logic [15:0]      dat_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = dword_i[{ofs_i, 3'b000} +: 8];
    half_w = dword_i[{ofs_i[2:1], 4'b0000} +: 16];
    if (siz_i) begin
      dat_o = half_w;
    end else begin
      dat_o = {{8{signed_i & byte_w[7]}}, byte_w};
    end
  end

endmodule

// File: rtl/widener.sv
// 16-bit to 64-bit bus responder; WIDENER_LINEBUF_EN adds a one-dword read line buffer.
// Hit read acks one cycle after the request; miss/write ack one cycle after s_ack_i, which may stall freely.
module widener
  import widener_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] m_adr_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic        m_siz_i,
  input  logic        m_signed_i,
  input  logic [15:0] m_dat_i,
  output logic        m_ack_o,
  output logic [15:0] m_dat_o,
  output logic [63:0] s_adr_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [7:0]  s_sel_o,
  output logic [63:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [63:0] s_dat_i
);

  state_e           state_q, state_d;
  logic             m_ack_q, m_ack_d;
  logic [15:0]      m_dat_q, m_dat_d;
  logic [63:0]      s_adr_q, s_adr_d;
  logic             s_cyc_q, s_cyc_d;
  logic             s_we_q, s_we_d;
  logic [7:0]       s_sel_q, s_sel_d;
  logic [63:0]      s_dat_q, s_dat_d;
  logic [OFS_W-1:0] ofs_q, ofs_d;
  logic             siz_q, siz_d;
  logic             sgn_q, sgn_d;

  logic             req;
  logic             rd_hit;
  logic [63:0]      lane_dword;
  logic [OFS_W-1:0] lane_ofs;
  logic             lane_siz;
  logic             lane_sgn;
  logic [15:0]      lane_dat;

  assign req = m_cyc_i & m_stb_i;

  // In IDLE the lane decodes the live request (hit path); otherwise the latched one.
  assign lane_ofs = (state_q == IDLE) ? m_adr_i[OFS_W-1:0] : ofs_q;
  assign lane_siz = (state_q == IDLE) ? m_siz_i : siz_q;
  assign lane_sgn = (state_q == IDLE) ? m_signed_i : sgn_q;

`ifdef WIDENER_LINEBUF_EN
  logic [63:0]      buf_q, buf_d;
  logic [63-OFS_W:0] tag_q, tag_d;
  logic             vld_q, vld_d;
  logic             wr_hit;

  assign rd_hit     = vld_q & (tag_q == m_adr_i[63:OFS_W]);
  assign wr_hit     = vld_q & (tag_q == s_adr_q[63:OFS_W]);
  assign lane_dword = (state_q == IDLE) ? buf_q : s_dat_i;
`else
  assign rd_hit     = 1'b0;
  assign lane_dword = s_dat_i;
`endif

  widener_lane u_lane (
    .dword_i  (lane_dword),
    .ofs_i    (lane_ofs),
    .siz_i    (lane_siz),
    .signed_i (lane_sgn),
    .dat_o    (lane_dat)
  );

  always_comb begin
    state_d = state_q;
    m_ack_d = 1'b0;
    m_dat_d = m_dat_q;
    s_adr_d = s_adr_q;
    s_cyc_d = s_cyc_q;
    s_we_d  = s_we_q;
    s_sel_d = s_sel_q;
    s_dat_d = s_dat_q;
    ofs_d   = ofs_q;
    siz_d   = siz_q;
    sgn_d   = sgn_q;
`ifdef WIDENER_LINEBUF_EN
    buf_d   = buf_q;
    tag_d   = tag_q;
    vld_d   = vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          ofs_d = m_adr_i[OFS_W-1:0];
          siz_d = m_siz_i;
          sgn_d = m_signed_i;
          if (!m_we_i && rd_hit) begin
            state_d = ACK;
            m_ack_d = 1'b1;
            m_dat_d = lane_dat;
          end else begin
            state_d = m_we_i ? STORE : FETCH;
            s_cyc_d = 1'b1;
            s_we_d  = m_we_i;
            s_adr_d = {m_adr_i[63:OFS_W], {OFS_W{1'b0}}};
            s_sel_d = m_we_i ? lane_mask(m_adr_i[OFS_W-1:0], m_siz_i) : 8'hFF;
            if (m_we_i) begin
              s_dat_d = m_siz_i ? {HALF_LANES{m_dat_i}} : {BYTE_LANES{m_dat_i[7:0]}};
            end
          end
        end
      end
      FETCH, STORE: begin
        if (!m_cyc_i || s_ack_i) begin
          s_cyc_d = 1'b0;
          s_we_d  = 1'b0;
          s_sel_d = 8'h00;
        end
        // Abort takes priority over a coincident slave ack.
        if (!m_cyc_i) begin
          state_d = IDLE;
`ifdef WIDENER_LINEBUF_EN
          if (state_q == STORE) vld_d = 1'b0;
`endif
        end else if (s_ack_i) begin
          state_d = ACK;
          m_ack_d = 1'b1;
          if (state_q == FETCH) begin
            m_dat_d = lane_dat;
`ifdef WIDENER_LINEBUF_EN
            buf_d = s_dat_i;
            tag_d = s_adr_q[63:OFS_W];
            vld_d = 1'b1;
`endif
          end
`ifdef WIDENER_LINEBUF_EN
          if (state_q == STORE && wr_hit) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
              if (s_sel_q[i]) buf_d[8*i +: 8] = s_dat_q[8*i +: 8];
            end
          end
`endif
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      m_ack_q <= 1'b0;
      m_dat_q <= '0;
      s_adr_q <= '0;
      s_cyc_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_dat_q <= '0;
      ofs_q   <= '0;
      siz_q   <= 1'b0;
      sgn_q   <= 1'b0;
`ifdef WIDENER_LINEBUF_EN
      buf_q   <= '0;
      tag_q   <= '0;
      vld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_ack_q <= m_ack_d;
      m_dat_q <= m_dat_d;
      s_adr_q <= s_adr_d;
      s_cyc_q <= s_cyc_d;
      s_we_q  <= s_we_d;
      s_sel_q <= s_sel_d;
      s_dat_q <= s_dat_d;
      ofs_q   <= ofs_d;
      siz_q   <= siz_d;
      sgn_q   <= sgn_d;
`ifdef WIDENER_LINEBUF_EN
      buf_q   <= buf_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
`endif
    end
  end

  assign m_ack_o = m_ack_q;
  assign m_dat_o = m_dat_q;
  assign s_adr_o = s_adr_q;
  assign s_cyc_o = s_cyc_q;
  assign s_stb_o = s_cyc_q;
  assign s_we_o  = s_we_q;
  assign s_sel_o = s_sel_q;
  assign s_dat_o = s_dat_q;

endmodule

// File: tb/tb_widener.sv
// Directed table-driven bench for widener, with a write-through dword memory as the slave.
// Expectations hold with or without WIDENER_LINEBUF_EN; only slave-cycle presence on hits differs.
module tb_widener;

`ifdef WIDENER_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk_i, reset_i;
  logic [63:0] m_adr_i;
  logic        m_cyc_i, m_stb_i, m_we_i, m_siz_i, m_signed_i;
  logic [15:0] m_dat_i;
  logic        m_ack_o;
  logic [15:0] m_dat_o;
  logic [63:0] s_adr_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [7:0]  s_sel_o;
  logic [63:0] s_dat_o;
  logic        s_ack_i;
  logic [63:0] s_dat_i;

  widener dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_siz_i(m_siz_i), .m_signed_i(m_signed_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic        siz;
    logic        sgn;
    logic [63:0] adr;
    logic [15:0] wdat;
    int          waits;
    logic        hit;
    logic [7:0]  sel;
    logic [63:0] sdat;
    logic [15:0] rd;
  } vec_t;

  localparam logic [63:0] A     = 64'h4444_3333_2222_1110;
  localparam logic [63:0] JUNK  = 64'hA5A5_A5A5_A5A5_A5A5;

  vec_t        vt [19];
  logic [63:0] mem [logic [60:0]];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ack"}, m_ack_o, 0);
    chk({tag, "_m_dat"}, m_dat_o, 0);
    chk({tag, "_s_adr"}, s_adr_o, 0);
    chk({tag, "_s_cyc"}, s_cyc_o, 0);
    chk({tag, "_s_stb"}, s_stb_o, 0);
    chk({tag, "_s_we"},  s_we_o,  0);
    chk({tag, "_s_sel"}, s_sel_o, 0);
    chk({tag, "_s_dat"}, s_dat_o, 0);
  endtask

  function automatic logic [63:0] mem_rd(input logic [60:0] key);
    return mem.exists(key) ? mem[key] : 64'h0;
  endfunction

  task automatic start_req(input logic we, input logic siz, input logic sgn,
                           input logic [63:0] adr, input logic [15:0] wd);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_siz_i = siz;
    m_signed_i = sgn; m_adr_i = adr; m_dat_i = wd;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic        exp_slv;
    logic [63:0] d;
    v = vt[i];
    exp_slv = v.we | ~(LB & v.hit);
    start_req(v.we, v.siz, v.sgn, v.adr, v.wdat);
    @(posedge clk_i); #1;
    chk($sformatf("v%0d_slave_cycle", i), s_stb_o, exp_slv);
    if (s_stb_o) begin
      chk($sformatf("v%0d_s_cyc", i), s_cyc_o, 1);
      chk($sformatf("v%0d_s_adr", i), s_adr_o, {v.adr[63:3], 3'b000});
      chk($sformatf("v%0d_s_sel", i), s_sel_o, v.sel);
      chk($sformatf("v%0d_s_we", i),  s_we_o,  v.we);
      if (v.we) chk($sformatf("v%0d_s_dat", i), s_dat_o, v.sdat);
      for (int w = 0; w < v.waits; w++) begin
        @(posedge clk_i); #1;
        chk($sformatf("v%0d_wait%0d_stb", i, w), s_stb_o, 1);
        chk($sformatf("v%0d_wait%0d_ack", i, w), m_ack_o, 0);
      end
      s_ack_i = 1'b1;
      s_dat_i = mem_rd(v.adr[63:3]);
      if (v.we) begin
        d = mem_rd(v.adr[63:3]);
        for (int b = 0; b < 8; b++) if (v.sel[b]) d[8*b +: 8] = v.sdat[8*b +: 8];
        mem[v.adr[63:3]] = d;
      end
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      s_dat_i = JUNK;
      chk($sformatf("v%0d_stb_fall", i), s_stb_o, 0);
    end
    chk($sformatf("v%0d_m_ack", i), m_ack_o, 1);
    chk($sformatf("v%0d_m_dat", i), m_dat_o, v.rd);
    @(posedge clk_i); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    chk($sformatf("v%0d_ack_pulse", i), m_ack_o, 0);
  endtask

  initial begin
    //           we    siz   sgn   adr            wdat      w  hit   sel    sdat                    rd
    vt[0]  = '{1'b0, 1'b0, 1'b1, A + 64'd1,    16'h0000, 3, 1'b0, 8'hFF, 64'h0,                 16'hFFAA};
    vt[1]  = '{1'b0, 1'b0, 1'b0, A + 64'd1,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h00AA};
    vt[2]  = '{1'b0, 1'b1, 1'b0, A + 64'd6,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h0000};
    vt[3]  = '{1'b1, 1'b1, 1'b0, A + 64'd2,    16'hBEEF, 0, 1'b1, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 16'h0000};
    vt[4]  = '{1'b0, 1'b1, 1'b1, A + 64'd3,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'hBEEF};
    vt[5]  = '{1'b0, 1'b0, 1'b1, A + 64'd3,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'hFFBE};
    vt[6]  = '{1'b0, 1'b0, 1'b0, A + 64'd2,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h00EF};
    vt[7]  = '{1'b1, 1'b0, 1'b0, A + 64'd7,    16'h775A, 1, 1'b1, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A, 16'h00EF};
    vt[8]  = '{1'b0, 1'b1, 1'b0, A + 64'd6,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h5A00};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 64'h24,       16'h0000, 2, 1'b0, 8'hFF, 64'h0,                 16'h3344};
    vt[10] = '{1'b0, 1'b0, 1'b1, 64'h27,       16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h0011};
    vt[11] = '{1'b1, 1'b0, 1'b0, 64'h40,       16'h0080, 0, 1'b0, 8'h01, 64'h8080_8080_8080_8080, 16'h0011};
    vt[12] = '{1'b0, 1'b0, 1'b1, 64'h40,       16'h0000, 0, 1'b0, 8'hFF, 64'h0,                 16'hFF80};
    vt[13] = '{1'b0, 1'b0, 1'b1, A + 64'd1,    16'h0000, 0, 1'b0, 8'hFF, 64'h0,                 16'hFFAA};
    vt[14] = '{1'b0, 1'b0, 1'b1, A + 64'd1,    16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'hFFAA};
    vt[15] = '{1'b0, 1'b1, 1'b0, 64'h100,      16'h0000, 1, 1'b0, 8'hFF, 64'h0,                 16'hC3D2};
    vt[16] = '{1'b0, 1'b0, 1'b0, 64'h101,      16'h0000, 0, 1'b1, 8'hFF, 64'h0,                 16'h00C3};
    vt[17] = '{1'b0, 1'b0, 1'b0, 64'h101,      16'h0000, 0, 1'b0, 8'hFF, 64'h0,                 16'h00C3};
    vt[18] = '{1'b0, 1'b0, 1'b0, 64'h101,      16'h0000, 0, 1'b0, 8'hFF, 64'h0,                 16'h00C3};

    mem[A[63:3]]          = 64'h0000_0000_0000_AA00;
    mem[61'h4]            = 64'h1122_3344_5566_7788;
    mem[61'h20]           = 64'h0000_0000_0000_C3D2;

    reset_i = 1'b1; m_adr_i = '0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_siz_i = 1'b0; m_signed_i = 1'b0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = JUNK;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    reset_i = 1'b0;

    for (int i = 0; i <= 13; i++) run_vec(i);

    // Aborted fetch: slave cycle dropped, no ack, buffer keeps dword A.
    start_req(1'b0, 1'b1, 1'b0, 64'h100, 16'h0);
    @(posedge clk_i); #1;
    chk("abort_fetch_stb", s_stb_o, 1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_fetch_cyc", s_cyc_o, 0);
    chk("abort_fetch_noack", m_ack_o, 0);
    @(posedge clk_i); #1;
    chk("abort_fetch_noack2", m_ack_o, 0);
    run_vec(14);
    run_vec(15);

    // Abort coinciding with a slave ack: abort wins, buffer (dword 0x100) untouched.
    start_req(1'b0, 1'b0, 1'b0, 64'h200, 16'h0);
    @(posedge clk_i); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk_i); #1;
    s_ack_i = 1'b0; s_dat_i = JUNK;
    chk("abort_ack_noack", m_ack_o, 0);
    chk("abort_ack_cyc", s_cyc_o, 0);
    chk("abort_ack_mdat", m_dat_o, 16'hC3D2);
    run_vec(16);

    // Aborted store invalidates the buffer, so the next read misses.
    start_req(1'b1, 1'b1, 1'b0, 64'h102, 16'h1234);
    @(posedge clk_i); #1;
    chk("abort_store_we", s_we_o, 1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_store_cyc", s_cyc_o, 0);
    chk("abort_store_noack", m_ack_o, 0);
    run_vec(17);

    // Reset while a store waits on the slave.
    start_req(1'b1, 1'b0, 1'b0, 64'h300, 16'h0055);
    @(posedge clk_i); #1;
    chk("rst_store_stb", s_stb_o, 1);
    reset_i = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk_all_zero("rst_store");
    run_vec(18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/widener.md
# widener

Responder for the 16-bit narrow bus that `bottleneck` drives, widening each byte or halfword access onto a 64-bit slave bus (memory or a wide peripheral fabric). It sits between `bottleneck`'s `s_*` side and 64-bit RAM. It keeps a one-dword read line buffer so that successive narrow reads within the same aligned 8-byte word finish without a slave cycle. Writes go through to the slave bus and update the buffer on a hit.

## Interface
- No parameters; all widths are fixed. The master side is 16-bit data with 64-bit address; the slave side is 64-bit data.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `m_adr_i` in 64: byte address from the narrow initiator.
- `m_cyc_i` in 1: cycle in progress.
- `m_stb_i` in 1: request strobe.
- `m_we_i` in 1: 1 selects write.
- `m_siz_i` in 1: 0 selects byte, 1 selects halfword.
- `m_signed_i` in 1: sign-extend byte reads to 16 bits.
- `m_dat_i` in 16: write data; a byte write uses `[7:0]`.
- `m_ack_o` out 1: one-cycle completion pulse.
- `m_dat_o` out 16: read data.
- `s_adr_o` out 64: dword-aligned address; `[2:0]` is always 0.
- `s_cyc_o` out 1: slave cycle in progress.
- `s_stb_o` out 1: slave strobe.
- `s_we_o` out 1: slave write.
- `s_sel_o` out 8: byte lane enables.
- `s_dat_o` out 64: slave write data.
- `s_ack_i` in 1: slave acknowledge.
- `s_dat_i` in 64: slave read data.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - FETCH: slave read outstanding.
  - STORE: slave write outstanding.
  - ACK: `m_ack_o` is high.
- **Request acceptance:** a request is accepted only in IDLE, on a clock edge where `m_cyc_i & m_stb_i` is high. The address, size, sign, we and data are latched at that edge.
- **Lane selection:**
  - Halfword: `adr[2:1]` selects the lane, and `adr[0]` is ignored (the access is forced aligned).
  - Byte: `adr[2:0]` selects the lane.
- **Read data extension:**
  - Byte read: `m_dat_o[15:8]` is `{8{byte[7]}}` if `m_signed_i` is set, otherwise 0.
  - Halfword read: `m_dat_o` is the halfword unchanged; `m_signed_i` is ignored.
- **Read hit** (buffer valid and `adr[63:3]` equals the tag): IDLE → ACK. `m_dat_o` is loaded from the buffer and no slave cycle runs.
- **Read miss:** IDLE → FETCH with `s_cyc_o`, `s_stb_o` = 1, `s_we_o` = 0 and `s_sel_o` = FF.
  - On `s_ack_i`, `s_dat_i` is captured into the buffer, the tag is set, valid is set, `m_dat_o` is loaded, and the state goes to ACK.
- **Write:** IDLE → STORE with `s_we_o` = 1.
  - `s_dat_o` carries the byte replicated ×8, or the halfword replicated ×4.
  - `s_sel_o` is a one-hot byte mask, or a two-bit mask for a halfword.
  - On `s_ack_i`, the state goes to ACK. If the write hits the buffer, the selected buffer bytes are merged; on a miss the buffer is left unchanged.
- **ACK:** `m_ack_o` = 1 for exactly one cycle, then IDLE. The master removes or replaces its strobe at the edge where it samples the ack.
- **Abort:** if `m_cyc_i` = 0 in FETCH or STORE, the block drops `s_cyc_o`/`s_stb_o` and returns to IDLE with no ack.
  - An aborted FETCH leaves the buffer untouched.
  - An aborted STORE invalidates the buffer.
  - If the abort and `s_ack_i` arrive on the same edge, the abort wins.
- **Reset:** `reset_i` at any edge (including mid-FETCH or mid-STORE) forces IDLE and clears valid.

## Timing
- Every output is registered.
- **Reset values:** all outputs are 0, including `m_dat_o` and `s_adr_o`.
- **Hit read:** request sampled at edge N; `m_ack_o` is high in cycle N+1.
- **Miss read or write:** `s_stb_o` rises at edge N. With `s_ack_i` sampled at edge N+k, `m_ack_o` is high in cycle N+k+1.
  - The minimum is 2 cycles of latency when k = 1.
- **Slave side deassertion:** `s_cyc_o`/`s_stb_o` fall at the same edge where `s_ack_i` is sampled.
- **Hold behaviour:** `m_dat_o` holds its last read value until the next read completes; writes do not change it.

## Configuration
- `WIDENER_LINEBUF_EN`
  - **Defined:** the line buffer, tag and valid bit are present, with the hit path as described above.
  - **Undefined:** every read is a miss; there is no buffer storage or tag logic, and writes skip the merge. Port behaviour is otherwise identical.

## Structure
- `widener_pkg` holds:
  - the state encodings IDLE/FETCH/STORE/ACK;
  - the dword offset width (3);
  - the lane-count constants.
- One sub-module, `widener_lane`: a combinational extractor taking a 64-bit dword, offset, size and signed flag, and producing 16-bit extended data. It is shared by the hit path and the miss path.

## Test plan
- **Byte read miss, signed:** `adr` 4444_3333_2222_1111, `s_dat_i` 0000_0000_0000_AA00 → `s_adr_o` 4444_3333_2222_1110, `s_sel_o` FF; `m_dat_o` FFAA with `m_ack_o` pulsing once. Unsigned repeat → 00AA.
- **Halfword read hit:** after the previous read, read `adr` …1116 → no `s_stb_o`; `m_dat_o` 0000 in cycle N+1. (With `WIDENER_LINEBUF_EN` undefined, a slave cycle occurs.)
- **Halfword write hit:** `adr` …1112, `m_dat_i` BEEF → `s_sel_o` 0C, `s_dat_o` BEEF_BEEF_BEEF_BEEF, `s_we_o` 1. A following read of …1112 hits and returns BEEF.
- **Abort:** drop `m_cyc_i` mid-FETCH while `s_ack_i` = 0 → `s_cyc_o` 0 next cycle and no `m_ack_o`. A later read of the same dword still issues a slave cycle.
- **Reset mid-STORE:** assert `reset_i` while STORE is waiting → all outputs 0 next cycle. The next read misses.
- **Wait states:** hold `s_ack_i` low for 3 cycles → `s_stb_o` stays high, `m_ack_o` stays low, and the ack comes exactly one cycle after `s_ack_i`.
